// File: rtl/reg_wb_queue_if.sv
// reg_wb_queue_if
//   Writeback request channel into the register-file writeback queue.
//   master : requester (drives In_Valid/In_Wreg/In_Rn/In_Data, sees In_Ready)
//   slave  : reg_wb_queue (sees the request, drives In_Ready)
//   In_Valid  1   request present
//   In_Ready  1   queue can accept this cycle
//   In_Wreg   1   request writes a register (0 = consume, store nothing)
//   In_Rn     5   destination register number
//   In_Data   32  write data
interface reg_wb_queue_if;
    logic        In_Valid;
    logic        In_Ready;
    logic        In_Wreg;
    logic [4:0]  In_Rn;
    logic [31:0] In_Data;

    modport master (
        output In_Valid, In_Wreg, In_Rn, In_Data,
        input  In_Ready
    );

    modport slave (
        input  In_Valid, In_Wreg, In_Rn, In_Data,
        output In_Ready
    );
endinterface

// File: rtl/reg_wb_queue.sv
// reg_wb_queue
//   Two-entry in-order writeback queue in front of a register file. Each
//   accepted request {Rn, Data} is stored and later drained one per cycle
//   (unless Hold) into registered D / one-hot En outputs.
//   Optional feature macro: R0_WRITE_GUARD_EN -- when defined, writes to
//   register 0 are consumed without storing and counted in Drop_Cnt;
//   when undefined they are queued normally and Drop_Cnt is tied to 0.
// Ports
//   Clk       in   sole clock, rising edge
//   Clrn      in   synchronous active-low reset
//   req       if   request channel (slave modport)
//   Hold      in   register-file stall, blocks draining
//   D         out  registered write data
//   En        out  registered one-hot write enable, zero when idle
//   Pend      out  entries queued (0..2)
//   Busy      out  Pend != 0 or En != 0
//   Drop_Cnt  out  saturating count of suppressed register-0 writes
module reg_wb_queue (
    input  logic            Clk,
    input  logic            Clrn,
    reg_wb_queue_if.slave   req,
    input  logic            Hold,
    output logic [31:0]     D,
    output logic [31:0]     En,
    output logic [1:0]      Pend,
    output logic            Busy,
    output logic [7:0]      Drop_Cnt
);

    // FIFO storage, intentionally not reset
    logic [4:0]  rn_q   [2];
    logic [31:0] data_q [2];

    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [1:0]  pend_q, pend_d;
    logic [31:0] d_q, d_d;
    logic [31:0] en_q, en_d;

    logic accept;
    logic r0_hit;
    logic push;
    logic pop;

    assign req.In_Ready = (pend_q != 2'd2);

    always_comb begin
        accept = req.In_Valid && req.In_Ready && req.In_Wreg;
`ifdef R0_WRITE_GUARD_EN
        r0_hit = accept && (req.In_Rn == 5'd0);
`else
        r0_hit = 1'b0;
`endif
        push = accept && !r0_hit;
        pop  = (pend_q != 2'd0) && !Hold;
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        pend_d = pend_q;
        d_d    = d_q;
        en_d   = '0;

        if (pop) begin
            d_d    = data_q[head_q];
            en_d   = 32'h1 << rn_q[head_q];
            head_d = ~head_q;
        end

        if (push) begin
            tail_d = ~tail_q;
        end

        // push at Pend=2 is impossible (In_Ready=0), pop at Pend=0 likewise
        case ({push, pop})
            2'b10:   pend_d = pend_q + 2'd1;
            2'b01:   pend_d = pend_q - 2'd1;
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            pend_q <= 2'd0;
            d_q    <= '0;
            en_q   <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            pend_q <= pend_d;
            d_q    <= d_d;
            en_q   <= en_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Clrn && push) begin
            rn_q[tail_q]   <= req.In_Rn;
            data_q[tail_q] <= req.In_Data;
        end
    end

`ifdef R0_WRITE_GUARD_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (r0_hit && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clrn) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign Drop_Cnt = drop_q;
`else
    assign Drop_Cnt = '0;
`endif

    assign D    = d_q;
    assign En   = en_q;
    assign Pend = pend_q;
    assign Busy = (pend_q != 2'd0) || (en_q != 32'd0);

endmodule

// File: tb/tb_reg_wb_queue.sv
module tb_reg_wb_queue;

    typedef struct {
        logic [4:0]  rn;
        logic [31:0] data;
    } exp_t;

    logic        Clk;
    logic        Clrn;
    logic        Hold;
    logic [31:0] D;
    logic [31:0] En;
    logic [1:0]  Pend;
    logic        Busy;
    logic [7:0]  Drop_Cnt;

    reg_wb_queue_if bus ();

    reg_wb_queue dut (
        .Clk      (Clk),
        .Clrn     (Clrn),
        .req      (bus.slave),
        .Hold     (Hold),
        .D        (D),
        .En       (En),
        .Pend     (Pend),
        .Busy     (Busy),
        .Drop_Cnt (Drop_Cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    exp_t sb[$];
    int   checks;
    int   errors;

    function automatic bit guard_drop(input logic [4:0] rn);
`ifdef R0_WRITE_GUARD_EN
        return (rn == 5'd0);
`else
        return (rn == 5'd0) && 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] rn,
                         input logic [31:0] data, input logic hold);
        @(negedge Clk);
        bus.In_Valid = v;
        bus.In_Wreg  = w;
        bus.In_Rn    = rn;
        bus.In_Data  = data;
        Hold         = hold;
    endtask

    // One rising edge; records the expected writeback if the request is stored.
    task automatic tick();
        bit   acc;
        exp_t e;
        acc    = bus.In_Valid && bus.In_Ready && bus.In_Wreg && !guard_drop(bus.In_Rn);
        e.rn   = bus.In_Rn;
        e.data = bus.In_Data;
        @(posedge Clk);
        if (!Clrn) sb.delete();
        else if (acc) sb.push_back(e);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Clrn   = 1'b0;
        Hold   = 1'b0;
        bus.In_Valid = 1'b0;
        bus.In_Wreg  = 1'b0;
        bus.In_Rn    = '0;
        bus.In_Data  = '0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(posedge Clk);
                    #1;
                    if (En !== 32'd0) begin
                        checks++;
                        if (!$onehot(En)) begin
                            errors++;
                            $display("FAIL mon_onehot: En=%h", En);
                        end else if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL mon_unexpected: En=%h D=%h expected no write", En, D);
                        end else begin
                            e = sb.pop_front();
                            if (En !== (32'h1 << e.rn) || D !== e.data) begin
                                errors++;
                                $display("FAIL mon_write: En=%h D=%h expected En=%h D=%h",
                                         En, D, 32'h1 << e.rn, e.data);
                            end
                        end
                    end
                end
            end
        join_none

        // reset state
        tick();
        tick();
        chk("rst_pend", {30'd0, Pend}, 32'd0);
        chk("rst_en", En, 32'd0);
        chk("rst_d", D, 32'd0);
        chk("rst_ready", {31'd0, bus.In_Ready}, 32'd1);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_drop", {24'd0, Drop_Cnt}, 32'd0);
        Clrn = 1'b1;

        // single write latency
        drive(1, 1, 5'd5, 32'hDEADBEEF, 0);
        tick();
        chk("lat_pend1", {30'd0, Pend}, 32'd1);
        chk("lat_en_t", En, 32'd0);
        drive(0, 0, 5'd0, 32'd0, 0);
        tick();
        chk("lat_en_t1", En, 32'h00000020);
        chk("lat_d_t1", D, 32'hDEADBEEF);
        tick();
        chk("lat_en_t2", En, 32'd0);
        chk("lat_busy_t2", {31'd0, Busy}, 32'd0);
        chk("lat_dhold", D, 32'hDEADBEEF);

        // hold fills queue, third request retried
        drive(1, 1, 5'd1, 32'hA1A1A1A1, 1);
        tick();
        drive(1, 1, 5'd2, 32'hA2A2A2A2, 1);
        tick();
        chk("hold_pend2", {30'd0, Pend}, 32'd2);
        drive(1, 1, 5'd3, 32'hA3A3A3A3, 1);
        chk("hold_ready0", {31'd0, bus.In_Ready}, 32'd0);
        tick();
        chk("hold_frozen_pend", {30'd0, Pend}, 32'd2);
        chk("hold_frozen_en", En, 32'd0);
        drive(1, 1, 5'd3, 32'hA3A3A3A3, 0);
        tick();
        chk("rel_en_rn1", En, 32'h2);
        chk("rel_pend", {30'd0, Pend}, 32'd1);
        drive(1, 1, 5'd3, 32'hA3A3A3A3, 0);
        tick();
        chk("rel_en_rn2", En, 32'h4);
        chk("rel_pend_pushpop", {30'd0, Pend}, 32'd1);
        drive(0, 0, 5'd0, 32'd0, 0);
        tick();
        chk("rel_en_rn3", En, 32'h8);
        chk("rel_d_rn3", D, 32'hA3A3A3A3);
        tick();

        // simultaneous push and pop at Pend=1
        drive(1, 1, 5'd4, 32'hB4B4B4B4, 1);
        tick();
        drive(1, 1, 5'd7, 32'hB7B7B7B7, 0);
        tick();
        chk("pp_pend", {30'd0, Pend}, 32'd1);
        chk("pp_en_head", En, 32'h10);
        drive(0, 0, 5'd0, 32'd0, 0);
        tick();
        chk("pp_en_rn7", En, 32'h80);
        tick();

        // consumed without storing
        drive(1, 0, 5'd9, 32'hC9C9C9C9, 0);
        tick();
        chk("nowreg_pend", {30'd0, Pend}, 32'd0);
        drive(0, 0, 5'd0, 32'd0, 0);
        tick();
        chk("nowreg_en", En, 32'd0);
        chk("nowreg_drop", {24'd0, Drop_Cnt}, 32'd0);

        // reset with full queue under hold
        drive(1, 1, 5'd10, 32'h0A0A0A0A, 1);
        tick();
        drive(1, 1, 5'd11, 32'h0B0B0B0B, 1);
        tick();
        chk("rq_pend2", {30'd0, Pend}, 32'd2);
        drive(1, 1, 5'd12, 32'h0C0C0C0C, 1);
        Clrn = 1'b0;
        tick();
        Clrn = 1'b1;
        chk("rq_pend0", {30'd0, Pend}, 32'd0);
        chk("rq_en0", En, 32'd0);
        chk("rq_d0", D, 32'd0);
        chk("rq_ready", {31'd0, bus.In_Ready}, 32'd1);
        chk("rq_busy", {31'd0, Busy}, 32'd0);
        drive(0, 0, 5'd0, 32'd0, 0);
        tick();
        tick();
        tick();
        chk("rq_no_write", En, 32'd0);

        // register-0 handling
`ifdef R0_WRITE_GUARD_EN
        for (int i = 0; i < 300; i++) begin
            drive(1, 1, 5'd0, 32'(i), 0);
            tick();
            if (i == 0) chk("g_drop_first", {24'd0, Drop_Cnt}, 32'd1);
            if (i == 254) chk("g_drop_255", {24'd0, Drop_Cnt}, 32'hFF);
        end
        drive(0, 0, 5'd0, 32'd0, 0);
        tick();
        chk("g_drop_sat", {24'd0, Drop_Cnt}, 32'hFF);
        chk("g_en0", En, 32'd0);
        chk("g_pend0", {30'd0, Pend}, 32'd0);
`else
        drive(1, 1, 5'd0, 32'hE0E0E0E0, 0);
        tick();
        drive(0, 0, 5'd0, 32'd0, 0);
        tick();
        chk("r0_en1", En, 32'h1);
        chk("r0_d", D, 32'hE0E0E0E0);
        chk("r0_drop0", {24'd0, Drop_Cnt}, 32'd0);
`endif

        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Clrn  input  1  synchronous active-low reset, sampled on rising Clk.
REQ-003 In_Valid  input  1  writeback request present.
REQ-004 In_Ready  output  1  queue can accept; combinational, In_Ready = (Pend != 2).
REQ-005 In_Wreg  input  1  request writes a register; 0 = request consumed, nothing stored.
REQ-006 In_Rn  input  5  destination register number.
REQ-007 In_Data  input  32  write data.
REQ-008 Hold  input  1  register file write stall; 1 blocks draining.
REQ-009 D  output  32  registered write data to register file D input.
REQ-010 En  output  32  registered one-hot write enable to register file En input; all-zero when idle.
REQ-011 Pend  output  2  entries currently queued, 0..2.
REQ-012 Busy  output  1  Pend != 0 or En != 0.
REQ-013 Drop_Cnt  output  8  saturating count of suppressed register-0 writes.

Function
REQ-014 Storage SHALL be a 2-entry FIFO of {Rn[4:0], Data[31:0]}, in-order, head/tail pointers wrapping modulo 2.
REQ-015 Push SHALL occur at an edge where In_Valid=1, In_Ready=1, In_Wreg=1; In_Valid=1 with In_Wreg=0 and In_Ready=1 SHALL be consumed without storing.
REQ-016 Pop SHALL occur at an edge where Pend != 0 and Hold=0; exactly one entry per edge.
REQ-017 On pop, D SHALL load head Data and En SHALL load (1 << head Rn) at the same edge.
REQ-018 On any edge without pop, En SHALL load 32'h0 and D SHALL hold its previous value.
REQ-019 Latency: request pushed at edge t into empty queue with Hold=0 SHALL be popped at edge t+1 and captured by the register file at edge t+2.
REQ-020 Simultaneous push and pop at Pend=1 SHALL leave Pend=1 with order preserved; no push at Pend=2 (In_Ready=0); at Pend=0 push without pop only.
REQ-021 Hold=1 SHALL freeze the queue contents; pushes continue until Pend=2.
REQ-022 En SHALL never have more than one bit set.
REQ-023 Drop_Cnt SHALL saturate at 8'hFF and never wrap.

Reset
REQ-024 Clrn=0 at an edge SHALL set Pend=0, pointers=0, En=32'h0, D=32'h0, Drop_Cnt=8'h0, discarding queued entries, overriding any simultaneous push or pop.
REQ-025 During and after reset In_Ready SHALL be 1 and Busy 0 until the first push.
REQ-026 FIFO storage contents need not be reset; only pointers and outputs.

Configuration
REQ-027 Macro R0_WRITE_GUARD_EN SHALL control register-0 protection.
REQ-028 With R0_WRITE_GUARD_EN defined: a request with In_Rn=0 and In_Wreg=1 SHALL be consumed as in REQ-015 without storing and SHALL increment Drop_Cnt.
REQ-029 Without R0_WRITE_GUARD_EN: In_Rn=0 requests SHALL be queued normally producing En=32'h1, and Drop_Cnt SHALL be constant 8'h0.

Verification
REQ-030 Reset then push {Rn=5, Data=32'hDEADBEEF}, Hold=0 -> two edges later En=32'h00000020, D=32'hDEADBEEF for one cycle, then En=0, Busy=0.
REQ-031 Hold=1, push Rn=1,2,3 back-to-back -> Pend=2, In_Ready=0 on third; release Hold -> En=32'h2 then 32'h4 on consecutive cycles, Rn=3 retried and written third.
REQ-032 Pend=1 with simultaneous push Rn=7 and pop -> Pend stays 1, En=head one-hot, then En=32'h80 next cycle.
REQ-033 Guard defined: 300 pushes with Rn=0 -> Drop_Cnt=8'hFF, En always 0; guard undefined: push Rn=0 -> En=32'h1.
REQ-034 Pend=2, Hold=1, Clrn=0 for one edge with In_Valid=1 -> Pend=0, En=0, D=0, In_Ready=1; no queued entry ever written after release.
REQ-035 Push with In_Wreg=0, Rn=9 -> Pend stays 0, En stays 0, Drop_Cnt unchanged.
